conv_sum_relu_pool: RTL and testbench
=====================================

Name: conv_sum_relu_pool

Overview:
Parametrised back-end stage for every conv layer in the CNN pipeline. It does four things in order:
- Sums NUM_CH per-channel 3x3 partial results for each of NUM_FILT filters, then adds a per-filter bias.
- Applies full POOLxPOOL non-overlapping max pooling across the whole IMG_W x IMG_H conv output map.
- Applies ReLU, arithmetic right-shift requantisation and saturation to OUT_BITS.
- Streams pooled pixels to the next layer with frame sync and error flagging.

It sits directly after the bank of conv_calc instances. It replaces the per-layer hand-written sum/pool logic.

Parameters:
NUM_FILT, 3, number of filters (output channels)
NUM_CH, 3, number of input channels summed per filter
ACC_BITS, 32, width of each signed partial result and bias
OUT_BITS, 12, width of each signed output pixel
IMG_W, 3, conv output map width in pixels (>= POOL)
IMG_H, 3, conv output map height in pixels (>= POOL)
POOL, 2, pooling window size and stride
SHIFT, 7, requantisation right-shift amount

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  partial_in holds one conv output pixel
sof_in  input  1  qualified by valid_in; this pixel is (x=0, y=0) of a new frame
partial_in  input  NUM_FILT*NUM_CH*ACC_BITS  signed partials; slice index f*NUM_CH+c
bias_in  input  NUM_FILT*ACC_BITS  signed per-filter bias, static during a frame
out_data  output  NUM_FILT*OUT_BITS  pooled, ReLU'd, requantised pixel; slice f
valid_out  output  1  one-cycle strobe; out_data valid
last_out  output  1  with valid_out; last pooled pixel of the frame
frame_err  output  1  one-cycle pulse; sof_in received while not at (0,0)

Behaviour:
- Reset: out_data=0, valid_out=0, last_out=0, frame_err=0. Counters, pipeline valid and row buffer all clear. Async assert, sync deassert inside clk domain. Reset mid-frame discards all partial state; the next valid_in is treated as (0,0).
- Stage 1 (registered, on valid_in):
  - sum_f = sum over c of partial + bias_f.
  - Internal width is ACC_BITS+clog2(NUM_CH+1)+1, sign-extended; no overflow possible.
- Stage 2 (pool, on stage-1 valid):
  - Pixel counters x in 0..IMG_W-1 and y in 0..IMG_H-1 advance only on accepted pixels.
  - Wrap rule: x wraps to 0 and increments y. At (IMG_W-1, IMG_H-1) both wrap to 0.
  - Pixels with x >= (IMG_W/POOL)*POOL or y >= (IMG_H/POOL)*POOL are ignored for pooling (floor mode) but still counted.
  - Column running max: a register per filter. It is loaded at window column 0 and max-updated at the other window columns.
  - Row buffer: depth IMG_W/POOL per filter, holding the window maxes.
    - At the last column of a window in window row 0, the running max is written to the buffer.
    - In later window rows it is merged as max(buffer, running max).
  - Emit: at the last column of the last row of a window, the pooled value m_f = max(buffer, running max).
- Stage 3 (output register):
  - ReLU + requantisation: r = (m_f <= 0) ? 0 : m_f >>> SHIFT.
  - If r > 2^(OUT_BITS-1)-1, out = 2^(OUT_BITS-1)-1 (saturate); otherwise out = r[OUT_BITS-1:0].
  - valid_out pulses for one cycle.
- Latency: valid_out is asserted 3 clk after the valid_in of the window's bottom-right pixel. Throughput is 1 pixel/clk.
- Output count per frame: (IMG_W/POOL)*(IMG_H/POOL), in raster order.
- last_out: high with the final pooled output. That output comes from the window ending at x=(IMG_W/POOL)*POOL-1, y=(IMG_H/POOL)*POOL-1.
- valid_in gaps of any length are allowed; state holds and outputs stay 0-strobed.
- sof_in with valid_in:
  - Counters are forced to (0,0) for that pixel.
  - If the counters were not already (0,0), frame_err pulses together with that pixel's stage-1 result, and the in-progress window/row state is discarded. No valid_out is generated from the aborted frame after the sof_in pixel.
  - sof_in without valid_in is ignored.
- out_data holds its last value between strobes.

Test Plan:
- Defaults (3x3, POOL 2, bias 0); pixel k (raster 0..8) has every partial = 128*k → one output per filter = (3*128*4)>>7 = 12, valid_out and last_out together 3 clk after pixel 4; pixels 5..8 produce nothing.
- Defaults, all partials -50, bias 0 → output 0 on all filters (ReLU); bias_in filter1 = +20000 → filter1 output (20000-150)>>7 = 155.
- Defaults, filter0 partial c0 = 2^19, others 0 → filter0 saturates to 2047; filter2 partial -2^19 → 0.
- IMG_W=5, IMG_H=4, partial c0 = 10*x+y, others 0, SHIFT 0 → 4 outputs in order 11, 31, 13, 33; last_out on 33; column x=4 ignored.
- Defaults, sof_in on pixel 2 of a frame → frame_err pulse; a following full 9-pixel frame yields the correct single output; no output from the aborted frame.
- Random valid_in gaps (0-5 idle clk) and rst_n low for 2 clk mid-frame → all outputs 0 during reset; post-reset frame is bit-exact vs the golden model.

Source files
------------

// File: rtl/conv_sum_relu_pool.sv
// rtl/conv_sum_relu_pool.sv - channel sum + bias, floor-mode max pool, ReLU/requantise/saturate, pixel streaming
module conv_sum_relu_pool #(
  parameter int NUM_FILT = 3,
  parameter int NUM_CH   = 3,
  parameter int ACC_BITS = 32,
  parameter int OUT_BITS = 12,
  parameter int IMG_W    = 3,
  parameter int IMG_H    = 3,
  parameter int POOL     = 2,
  parameter int SHIFT    = 7
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 valid_in,
  input  logic                                 sof_in,
  input  logic [NUM_FILT*NUM_CH*ACC_BITS-1:0]  partial_in,
  input  logic [NUM_FILT*ACC_BITS-1:0]         bias_in,
  output logic [NUM_FILT*OUT_BITS-1:0]         out_data,
  output logic                                 valid_out,
  output logic                                 last_out,
  output logic                                 frame_err
);

  localparam int SW  = ACC_BITS + $clog2(NUM_CH + 1) + 1;
  localparam int PW  = IMG_W / POOL;
  localparam int PH  = IMG_H / POOL;
  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PXW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int CW  = (PW > 1) ? $clog2(PW) : 1;

  typedef logic signed [SW-1:0] sum_t;

  localparam sum_t                OUT_MAX   = sum_t'((longint'(1) << (OUT_BITS - 1)) - 1);
  localparam logic [OUT_BITS-1:0] OUT_MAX_O = OUT_MAX[OUT_BITS-1:0];

  function automatic sum_t smax(input sum_t a, input sum_t b);
    return (a > b) ? a : b;
  endfunction

  // Stage 1 state
  logic s1_valid_q, s1_valid_d;
  logic s1_sof_q, s1_sof_d;
  sum_t s1_sum_q [NUM_FILT];
  sum_t s1_sum_d [NUM_FILT];

  // Stage 2 state: pixel position, window position, running maxes
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [PXW-1:0] px_q, px_d;
  logic [PXW-1:0] py_q, py_d;
  logic [CW-1:0]  col_q, col_d;
  sum_t cmax_q [NUM_FILT];
  sum_t cmax_d [NUM_FILT];
  sum_t rowbuf_q [PW][NUM_FILT];
  sum_t rowbuf_d [PW][NUM_FILT];
  logic s2_valid_q, s2_valid_d;
  logic s2_last_q, s2_last_d;
  sum_t s2_max_q [NUM_FILT];
  sum_t s2_max_d [NUM_FILT];

  // Stage 3 output registers
  logic [NUM_FILT*OUT_BITS-1:0] out_data_q, out_data_d;
  logic valid_out_q, valid_out_d;
  logic last_out_q, last_out_d;

  // Effective coordinates of the stage-1 pixel (a sof pixel is always at the origin)
  logic [XW-1:0]  x_c;
  logic [YW-1:0]  y_c;
  logic [PXW-1:0] px_c, py_c;
  logic [CW-1:0]  col_c;
  logic           in_pool, win_end_x, win_end_y;

  // Stage 1: sign-extended sum of all channel partials plus the filter bias
  always_comb begin
    s1_valid_d = valid_in;
    s1_sof_d   = valid_in & sof_in;
    s1_sum_d   = s1_sum_q;
    if (valid_in) begin
      for (int f = 0; f < NUM_FILT; f++) begin
        s1_sum_d[f] = sum_t'($signed(bias_in[f*ACC_BITS +: ACC_BITS]));
        for (int c = 0; c < NUM_CH; c++) begin
          s1_sum_d[f] = s1_sum_d[f] + sum_t'($signed(partial_in[(f*NUM_CH+c)*ACC_BITS +: ACC_BITS]));
        end
      end
    end
  end

  // A sof arriving anywhere but the origin aborts the frame; old window state is overwritten from (0,0)
  assign frame_err = s1_valid_q & s1_sof_q & ((x_q != '0) || (y_q != '0));

  // Stage 2: pixel counters, column running max, row buffer merge and window emit
  always_comb begin
    sum_t cm;
    sum_t merged;
    cm         = '0;
    merged     = '0;
    x_c        = s1_sof_q ? '0 : x_q;
    y_c        = s1_sof_q ? '0 : y_q;
    px_c       = s1_sof_q ? '0 : px_q;
    py_c       = s1_sof_q ? '0 : py_q;
    col_c      = s1_sof_q ? '0 : col_q;
    in_pool    = (int'(x_c) < PW*POOL) && (int'(y_c) < PH*POOL);
    win_end_x  = (int'(px_c) == POOL - 1);
    win_end_y  = (int'(py_c) == POOL - 1);
    x_d        = x_q;
    y_d        = y_q;
    px_d       = px_q;
    py_d       = py_q;
    col_d      = col_q;
    cmax_d     = cmax_q;
    rowbuf_d   = rowbuf_q;
    s2_max_d   = s2_max_q;
    s2_valid_d = 1'b0;
    s2_last_d  = 1'b0;
    if (s1_valid_q) begin
      if (in_pool) begin
        for (int f = 0; f < NUM_FILT; f++) begin
          cm        = (px_c == '0) ? s1_sum_q[f] : smax(cmax_q[f], s1_sum_q[f]);
          cmax_d[f] = cm;
          if (win_end_x) begin
            merged               = (py_c == '0) ? cm : smax(rowbuf_q[col_c][f], cm);
            rowbuf_d[col_c][f]   = merged;
            if (win_end_y) begin
              s2_max_d[f] = merged;
            end
          end
        end
        s2_valid_d = win_end_x & win_end_y;
        s2_last_d  = win_end_x & win_end_y & (int'(col_c) == PW - 1) & (int'(y_c) == PH*POOL - 1);
      end
      x_d   = x_c;
      y_d   = y_c;
      px_d  = px_c;
      py_d  = py_c;
      col_d = col_c;
      if (int'(x_c) == IMG_W - 1) begin
        x_d   = '0;
        px_d  = '0;
        col_d = '0;
        if (int'(y_c) == IMG_H - 1) begin
          y_d  = '0;
          py_d = '0;
        end else begin
          y_d  = y_c + 1'b1;
          py_d = win_end_y ? '0 : py_c + 1'b1;
        end
      end else begin
        x_d  = x_c + 1'b1;
        px_d = win_end_x ? '0 : px_c + 1'b1;
        if (win_end_x && (int'(col_c) < PW - 1)) begin
          col_d = col_c + 1'b1;
        end
      end
    end
  end

  // Stage 3: ReLU, arithmetic-shift requantisation and saturation to OUT_BITS
  always_comb begin
    sum_t r;
    r           = '0;
    valid_out_d = s2_valid_q;
    last_out_d  = s2_valid_q & s2_last_q;
    out_data_d  = out_data_q;
    if (s2_valid_q) begin
      for (int f = 0; f < NUM_FILT; f++) begin
        if (s2_max_q[f] <= 0) begin
          r = '0;
        end else begin
          r = s2_max_q[f] >>> SHIFT;
        end
        out_data_d[f*OUT_BITS +: OUT_BITS] = (r > OUT_MAX) ? OUT_MAX_O : r[OUT_BITS-1:0];
      end
    end
  end

  // Pipeline, counter and buffer registers; reset discards all frame state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      col_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      out_data_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      for (int f = 0; f < NUM_FILT; f++) begin
        s1_sum_q[f] <= '0;
        cmax_q[f]   <= '0;
        s2_max_q[f] <= '0;
        for (int b = 0; b < PW; b++) begin
          rowbuf_q[b][f] <= '0;
        end
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_sum_q    <= s1_sum_d;
      x_q         <= x_d;
      y_q         <= y_d;
      px_q        <= px_d;
      py_q        <= py_d;
      col_q       <= col_d;
      cmax_q      <= cmax_d;
      rowbuf_q    <= rowbuf_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_max_q    <= s2_max_d;
      out_data_q  <= out_data_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
    end
  end

  assign out_data  = out_data_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_conv_sum_relu_pool.sv
// tb/tb_conv_sum_relu_pool.sv - directed self-checking bench for conv_sum_relu_pool
module tb_conv_sum_relu_pool;

  localparam int NF = 3;
  localparam int NC = 3;
  localparam int AB = 32;
  localparam int OB = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic                  valid_in = 1'b0;
  logic                  sof_in = 1'b0;
  logic [NF*NC*AB-1:0]   partial_in = '0;
  logic [NF*AB-1:0]      bias_in = '0;
  logic [NF*OB-1:0]      out_data;
  logic                  valid_out, last_out, frame_err;

  // 5x4, SHIFT 0 instance
  logic                  v5 = 1'b0;
  logic                  s5 = 1'b0;
  logic [NF*NC*AB-1:0]   p5 = '0;
  logic [NF*AB-1:0]      b5 = '0;
  logic [NF*OB-1:0]      o5;
  logic                  vo5, lo5, fe5;

  conv_sum_relu_pool dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in),
    .partial_in(partial_in), .bias_in(bias_in), .out_data(out_data),
    .valid_out(valid_out), .last_out(last_out), .frame_err(frame_err)
  );

  conv_sum_relu_pool #(.IMG_W(5), .IMG_H(4), .SHIFT(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .valid_in(v5), .sof_in(s5),
    .partial_in(p5), .bias_in(b5), .out_data(o5),
    .valid_out(vo5), .last_out(lo5), .frame_err(fe5)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_cnt = 0;
  int err5_cnt = 0;
  logic [NF*OB-1:0] q_data[$];
  logic             q_last[$];
  int               q_cyc[$];
  logic [NF*OB-1:0] q5_data[$];
  logic             q5_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  // capture output strobes and error pulses away from the active edge
  always @(negedge clk) begin
    if (valid_out) begin
      q_data.push_back(out_data);
      q_last.push_back(last_out);
      q_cyc.push_back(cyc);
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (vo5) begin
      q5_data.push_back(o5);
      q5_last.push_back(lo5);
    end
    if (fe5) err5_cnt <= err5_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NF*NC*AB-1:0] fill(input logic [AB-1:0] v);
    logic [NF*NC*AB-1:0] r;
    for (int i = 0; i < NF*NC; i++) r[i*AB +: AB] = v;
    return r;
  endfunction

  function automatic logic [OB-1:0] golden(input longint m);
    longint r;
    if (m <= 0) return '0;
    r = m >>> 7;
    if (r > 2047) return 12'd2047;
    return r[OB-1:0];
  endfunction

  // one 3x3 frame with identical partials on every pixel, then pipeline flush
  task automatic send_const_frame(input logic [NF*NC*AB-1:0] p);
    for (int k = 0; k < 9; k++) begin
      step();
      valid_in = 1'b1; sof_in = (k == 0); partial_in = p;
    end
    step();
    valid_in = 1'b0; sof_in = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid_out got %b want 0", valid_out); end
    tests++; if (last_out !== 1'b0) begin fails++; $display("FAIL reset_last_out got %b want 0", last_out); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int n0, e0, c4;
    n0 = q_data.size(); e0 = err_cnt; c4 = 0;
    bias_in = '0;
    for (int k = 0; k < 9; k++) begin
      step();
      valid_in = 1'b1; sof_in = (k == 0); partial_in = fill(AB'(128*k));
      if (k == 4) c4 = cyc;
    end
    step();
    valid_in = 1'b0; sof_in = 1'b0;
    repeat (5) step();
    tests++;
    if (q_data.size() - n0 != 1) begin
      fails++; $display("FAIL basic_count got %0d want 1", q_data.size() - n0);
    end else begin
      for (int f = 0; f < NF; f++) begin
        tests++; if (q_data[n0][f*OB +: OB] !== 12'd12) begin fails++; $display("FAIL basic_data f%0d got %0d want 12", f, q_data[n0][f*OB +: OB]); end
      end
      tests++; if (q_last[n0] !== 1'b1) begin fails++; $display("FAIL basic_last got %b want 1", q_last[n0]); end
      tests++; if (q_cyc[n0] - c4 != 3) begin fails++; $display("FAIL basic_latency got %0d want 3", q_cyc[n0] - c4); end
    end
    tests++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL basic_no_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_relu_bias();
    int n0;
    logic [OB-1:0] exp1 [NF];
    n0 = q_data.size();
    bias_in = '0;
    send_const_frame(fill(-50));
    bias_in[1*AB +: AB] = 20000;
    send_const_frame(fill(-50));
    bias_in = '0;
    exp1[0] = 12'd0; exp1[1] = 12'd155; exp1[2] = 12'd0;
    tests++;
    if (q_data.size() - n0 != 2) begin
      fails++; $display("FAIL relu_count got %0d want 2", q_data.size() - n0);
    end else begin
      for (int f = 0; f < NF; f++) begin
        tests++; if (q_data[n0][f*OB +: OB] !== 12'd0) begin fails++; $display("FAIL relu_neg f%0d got %0d want 0", f, q_data[n0][f*OB +: OB]); end
        tests++; if (q_data[n0+1][f*OB +: OB] !== exp1[f]) begin fails++; $display("FAIL relu_bias f%0d got %0d want %0d", f, q_data[n0+1][f*OB +: OB], exp1[f]); end
      end
    end
  endtask

  task automatic test_saturate();
    int n0;
    logic [NF*NC*AB-1:0] p;
    logic [OB-1:0] expv [NF];
    n0 = q_data.size();
    p = '0;
    p[0*AB +: AB] = 32'sd524288;
    p[6*AB +: AB] = -32'sd524288;
    send_const_frame(p);
    expv[0] = 12'd2047; expv[1] = 12'd0; expv[2] = 12'd0;
    tests++;
    if (q_data.size() - n0 != 1) begin
      fails++; $display("FAIL sat_count got %0d want 1", q_data.size() - n0);
    end else begin
      for (int f = 0; f < NF; f++) begin
        tests++; if (q_data[n0][f*OB +: OB] !== expv[f]) begin fails++; $display("FAIL sat_data f%0d got %0d want %0d", f, q_data[n0][f*OB +: OB], expv[f]); end
      end
    end
  endtask

  task automatic test_floor_5x4();
    int n0, e0;
    logic [OB-1:0] expv [4];
    n0 = q5_data.size(); e0 = err5_cnt;
    expv[0] = 12'd11; expv[1] = 12'd31; expv[2] = 12'd13; expv[3] = 12'd33;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 5; x++) begin
        step();
        v5 = 1'b1; s5 = (x == 0 && y == 0); p5 = '0;
        for (int f = 0; f < NF; f++) p5[(f*NC)*AB +: AB] = 10*x + y;
      end
    end
    step();
    v5 = 1'b0; s5 = 1'b0;
    repeat (5) step();
    tests++;
    if (q5_data.size() - n0 != 4) begin
      fails++; $display("FAIL floor_count got %0d want 4", q5_data.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int f = 0; f < NF; f++) begin
          tests++; if (q5_data[n0+i][f*OB +: OB] !== expv[i]) begin fails++; $display("FAIL floor_data o%0d f%0d got %0d want %0d", i, f, q5_data[n0+i][f*OB +: OB], expv[i]); end
        end
        tests++; if (q5_last[n0+i] !== (i == 3)) begin fails++; $display("FAIL floor_last o%0d got %b want %b", i, q5_last[n0+i], (i == 3)); end
      end
    end
    tests++; if (err5_cnt - e0 != 0) begin fails++; $display("FAIL floor_no_err got %0d want 0", err5_cnt - e0); end
  endtask

  task automatic test_sof_abort();
    int n0, e0;
    n0 = q_data.size(); e0 = err_cnt;
    bias_in = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      valid_in = 1'b1; sof_in = (k == 0); partial_in = fill(AB'(128000));
    end
    for (int k = 0; k < 9; k++) begin
      step();
      valid_in = 1'b1; sof_in = (k == 0); partial_in = fill(AB'(128*k));
    end
    step();
    valid_in = 1'b0; sof_in = 1'b0;
    repeat (5) step();
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL sof_err_pulses got %0d want 1", err_cnt - e0); end
    tests++;
    if (q_data.size() - n0 != 1) begin
      fails++; $display("FAIL sof_count got %0d want 1", q_data.size() - n0);
    end else begin
      for (int f = 0; f < NF; f++) begin
        tests++; if (q_data[n0][f*OB +: OB] !== 12'd12) begin fails++; $display("FAIL sof_data f%0d got %0d want 12", f, q_data[n0][f*OB +: OB]); end
      end
      tests++; if (q_last[n0] !== 1'b1) begin fails++; $display("FAIL sof_last got %b want 1", q_last[n0]); end
    end
  endtask

  task automatic test_gaps_reset();
    int n0, gap, v;
    longint psum [9][NF];
    longint best;
    n0 = q_data.size();
    bias_in = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      valid_in = 1'b1; sof_in = (k == 0); partial_in = fill(AB'(128*(k+1)));
    end
    step();
    valid_in = 1'b0; sof_in = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (out_data !== '0) begin fails++; $display("FAIL rst_out_data c%0d got %h want 0", i, out_data); end
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid c%0d got %b want 0", i, valid_out); end
      tests++; if (last_out !== 1'b0) begin fails++; $display("FAIL rst_last c%0d got %b want 0", i, last_out); end
      step();
    end
    rst_n = 1'b1;
    repeat (5) step();
    tests++; if (q_data.size() - n0 != 0) begin fails++; $display("FAIL rst_discard got %0d want 0", q_data.size() - n0); end
    for (int fr = 0; fr < 3; fr++) begin
      n0 = q_data.size();
      for (int f = 0; f < NF; f++) begin
        v = int'($urandom_range(0, 10000)) - 5000;
        bias_in[f*AB +: AB] = v;
        for (int k = 0; k < 9; k++) psum[k][f] = v;
      end
      for (int k = 0; k < 9; k++) begin
        gap = int'($urandom_range(0, 5));
        repeat (gap) begin
          step();
          valid_in = 1'b0;
          for (int i = 0; i < NF*NC; i++) partial_in[i*AB +: AB] = $urandom();
        end
        step();
        valid_in = 1'b1; sof_in = 1'b0;
        for (int f = 0; f < NF; f++) begin
          for (int c = 0; c < NC; c++) begin
            v = int'($urandom_range(0, 200000)) - 100000;
            partial_in[(f*NC+c)*AB +: AB] = v;
            psum[k][f] += v;
          end
        end
      end
      step();
      valid_in = 1'b0;
      repeat (5) step();
      tests++;
      if (q_data.size() - n0 != 1) begin
        fails++; $display("FAIL rand_count fr%0d got %0d want 1", fr, q_data.size() - n0);
      end else begin
        for (int f = 0; f < NF; f++) begin
          best = psum[0][f];
          if (psum[1][f] > best) best = psum[1][f];
          if (psum[3][f] > best) best = psum[3][f];
          if (psum[4][f] > best) best = psum[4][f];
          tests++; if (q_data[n0][f*OB +: OB] !== golden(best)) begin fails++; $display("FAIL rand_data fr%0d f%0d got %0d want %0d", fr, f, q_data[n0][f*OB +: OB], golden(best)); end
        end
        tests++; if (q_last[n0] !== 1'b1) begin fails++; $display("FAIL rand_last fr%0d got %b want 1", fr, q_last[n0]); end
      end
    end
    bias_in = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_bias();
    test_saturate();
    test_floor_5x4();
    test_sof_abort();
    test_gaps_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
